// File: rtl/branch_resolve_unit_pkg.sv
// -----------------------------------------------------------------------------
// branch_resolve_unit_pkg
//   Shared definitions for the EX-stage branch resolve unit and its comparator.
//   - Branch-kind bit indices (BEQ..BGEU = 0..5) into the one-hot kind vector.
//   - Resolve FSM state encodings (RUN = 1'b0, SHADOW = 1'b1).
//   - kind_is_legal(): true when exactly one kind bit is set.
// -----------------------------------------------------------------------------
package branch_resolve_unit_pkg;

  localparam int BEQ       = 0;
  localparam int BNE       = 1;
  localparam int BLT       = 2;
  localparam int BGE       = 3;
  localparam int BLTU      = 4;
  localparam int BGEU      = 5;
  localparam int NUM_KINDS = 6;

  typedef logic [NUM_KINDS-1:0] kind_t;

  typedef enum logic {
    RUN    = 1'b0,
    SHADOW = 1'b1
  } state_e;

  // Exactly one bit set: non-zero and clearing the lowest set bit leaves zero.
  function automatic logic kind_is_legal(input kind_t kind);
    return (kind != '0) && ((kind & (kind - kind_t'(1))) == '0);
  endfunction

endpackage

// File: rtl/branch_resolve_unit_comparator.sv
// -----------------------------------------------------------------------------
// branch_comparator
//   Purely combinational branch condition evaluator. Shared by the EX-stage
//   resolve unit and intended for reuse by an ID-stage early resolver.
//
//   Parameters:
//     XLEN   operand width
//   Ports:
//     rs1    in  XLEN  first operand
//     rs2    in  XLEN  second operand
//     kind   in  6     one-hot branch kind (BEQ..BGEU)
//     taken  out 1     condition true; 0 for an illegal (zero/multi-hot) kind
// -----------------------------------------------------------------------------
module branch_comparator
  import branch_resolve_unit_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] rs1,
  input  logic [XLEN-1:0] rs2,
  input  kind_t           kind,
  output logic            taken
);

  kind_t hits;

  // NOTE: every signal written in always_comb gets a default first, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    hits       = '0;
    hits[BEQ]  = (rs1 == rs2);
    hits[BNE]  = (rs1 != rs2);
    hits[BLT]  = ($signed(rs1) <  $signed(rs2));
    hits[BGE]  = ($signed(rs1) >= $signed(rs2));
    hits[BLTU] = (rs1 <  rs2);
    hits[BGEU] = (rs1 >= rs2);
  end

  // A malformed kind vector must never look like a taken branch.
  assign taken = kind_is_legal(kind) && (|(kind & hits));

endmodule

// File: rtl/branch_resolve_unit.sv
// -----------------------------------------------------------------------------
// branch_resolve_unit
//   EX-stage branch resolution, directly downstream of the branch predictor.
//   Evaluates the B-type branch in EX, compares the real outcome with the
//   prediction piped from IF, raises a combinational redirect on mismatch and
//   registers a one-cycle "branch_failed" bundle used by the predictor and RAS
//   for rollback while the pipeline flushes. After a mispredict the unit sits
//   in SHADOW for SHADOW_CYCLES unstalled cycles, during which EX holds
//   wrong-path instructions that must not redirect again.
//
//   Optional build macro: BRANCH_PERF_CNT_EN adds saturating perf counters.
//
//   Parameters:
//     XLEN           operand / PC width
//     SHADOW_CYCLES  wrong-path cycles after a mispredict (1..3)
//   Ports:
//     clk, rst_n                      clock, async active-low reset
//     PL_stall, PL_stall_inner        stalls; hold all state, mask mispredict
//     B_type_ex                       EX holds a conditional branch
//     beq_ex..bgeu_ex                 one-hot branch kind
//     pc_ex, imme_ex                  branch PC and sign-extended offset
//     rs1_data, rs2_data              forwarded operands
//     prediction_ex                   predicted taken
//     corrected_result                real outcome (comb)
//     mispredict                      redirect request (comb)
//     redirect_pc                     pc_ex+imme_ex if taken else pc_ex+4 (comb)
//     B_type_branch_failed            registered failed-branch valid
//     beq..bgeu_branch_failed         registered kind of failed branch
//     pc_branch_filled                registered PC of failed branch
//     B_type_result_branch_failed     registered real outcome of failed branch
//     perf_branch_cnt                 [BRANCH_PERF_CNT_EN] branches seen in RUN
//     perf_mispredict_cnt             [BRANCH_PERF_CNT_EN] mispredicts raised
// -----------------------------------------------------------------------------
module branch_resolve_unit
  import branch_resolve_unit_pkg::*;
#(
  parameter int XLEN          = 32,
  parameter int SHADOW_CYCLES = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            PL_stall,
  input  logic            PL_stall_inner,
  input  logic            B_type_ex,
  input  logic            beq_ex,
  input  logic            bne_ex,
  input  logic            blt_ex,
  input  logic            bge_ex,
  input  logic            bltu_ex,
  input  logic            bgeu_ex,
  input  logic [XLEN-1:0] pc_ex,
  input  logic [XLEN-1:0] imme_ex,
  input  logic [XLEN-1:0] rs1_data,
  input  logic [XLEN-1:0] rs2_data,
  input  logic            prediction_ex,
  output logic            corrected_result,
  output logic            mispredict,
  output logic [XLEN-1:0] redirect_pc,
  output logic            B_type_branch_failed,
  output logic            beq_branch_failed,
  output logic            bne_branch_failed,
  output logic            blt_branch_failed,
  output logic            bge_branch_failed,
  output logic            bltu_branch_failed,
  output logic            bgeu_branch_failed,
  output logic [XLEN-1:0] pc_branch_filled,
  output logic            B_type_result_branch_failed
`ifdef BRANCH_PERF_CNT_EN
  ,
  output logic [31:0]     perf_branch_cnt,
  output logic [31:0]     perf_mispredict_cnt
`endif
);

  // Counter is wide enough for SHADOW_CYCLES up to 3 (loads 0..2).
  localparam logic [1:0] SHADOW_LOAD = 2'(SHADOW_CYCLES - 1);

  kind_t      kind;
  kind_t      failed_kind;
  logic       taken;
  logic       stall;
  state_e     state;
  state_e     state_next;
  logic [1:0] shadow_cnt;
  logic [1:0] shadow_cnt_next;

  assign kind[BEQ]  = beq_ex;
  assign kind[BNE]  = bne_ex;
  assign kind[BLT]  = blt_ex;
  assign kind[BGE]  = bge_ex;
  assign kind[BLTU] = bltu_ex;
  assign kind[BGEU] = bgeu_ex;

  assign stall = PL_stall | PL_stall_inner;

  branch_comparator #(
    .XLEN (XLEN)
  ) u_comparator (
    .rs1   (rs1_data),
    .rs2   (rs2_data),
    .kind  (kind),
    .taken (taken)
  );

  // --------------------------------------------------------------------------
  // Combinational resolution
  // --------------------------------------------------------------------------
  assign corrected_result = B_type_ex & taken;

  // Both targets wrap modulo 2^XLEN by construction of the XLEN-bit adds.
  assign redirect_pc = corrected_result ? (pc_ex + imme_ex) : (pc_ex + XLEN'(4));

  // Masked while stalled so the predictor rollback fires exactly once, on the
  // cycle the branch actually leaves EX.
  assign mispredict = B_type_ex && (corrected_result != prediction_ex) &&
                      (state == RUN) && !stall;

  // --------------------------------------------------------------------------
  // RUN / SHADOW FSM
  // --------------------------------------------------------------------------
  always_comb begin
    state_next      = state;
    shadow_cnt_next = shadow_cnt;
    if (!stall) begin
      case (state)
        RUN: begin
          if (mispredict) begin
            state_next      = SHADOW;
            shadow_cnt_next = SHADOW_LOAD;
          end
        end
        SHADOW: begin
          if (shadow_cnt == 2'd0) begin
            state_next = RUN;
          end else begin
            shadow_cnt_next = shadow_cnt - 2'd1;
          end
        end
        default: state_next = RUN;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of process evaluation order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= RUN;
      shadow_cnt <= 2'd0;
    end else begin
      state      <= state_next;
      shadow_cnt <= shadow_cnt_next;
    end
  end

  // --------------------------------------------------------------------------
  // Failed-branch bundle: valid/kind pulse for one unstalled cycle; PC and
  // outcome keep the last failed branch for late consumers.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      B_type_branch_failed        <= 1'b0;
      failed_kind                 <= '0;
      pc_branch_filled            <= '0;
      B_type_result_branch_failed <= 1'b0;
    end else if (!stall) begin
      B_type_branch_failed <= mispredict;
      failed_kind          <= mispredict ? kind : '0;
      if (mispredict) begin
        pc_branch_filled            <= pc_ex;
        B_type_result_branch_failed <= corrected_result;
      end
    end
  end

  assign beq_branch_failed  = failed_kind[BEQ];
  assign bne_branch_failed  = failed_kind[BNE];
  assign blt_branch_failed  = failed_kind[BLT];
  assign bge_branch_failed  = failed_kind[BGE];
  assign bltu_branch_failed = failed_kind[BLTU];
  assign bgeu_branch_failed = failed_kind[BGEU];

`ifdef BRANCH_PERF_CNT_EN
  // --------------------------------------------------------------------------
  // Saturating performance counters
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_branch_cnt     <= '0;
      perf_mispredict_cnt <= '0;
    end else begin
      if (!stall && B_type_ex && (state == RUN) && (perf_branch_cnt != '1)) begin
        perf_branch_cnt <= perf_branch_cnt + 32'd1;
      end
      if (mispredict && (perf_mispredict_cnt != '1)) begin
        perf_mispredict_cnt <= perf_mispredict_cnt + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_branch_resolve_unit.sv
// -----------------------------------------------------------------------------
// tb_branch_resolve_unit
//   Scoreboard bench: the stimulus process drives one vector per cycle and
//   pushes the reference model's expected outputs into a queue; a monitor
//   process pops and compares a snapshot of the DUT outputs each cycle.
//   Directed vectors cover the documented scenarios, followed by randomized
//   traffic with stalls, illegal kinds and occasional resets.
// -----------------------------------------------------------------------------
module tb_branch_resolve_unit;

  localparam int SC       = 1;
  localparam int N_RANDOM = 3000;

  typedef struct packed {
    logic        rst_n;
    logic        ps;
    logic        psi;
    logic        b;
    logic [5:0]  kind;   // bit0 beq .. bit5 bgeu
    logic [31:0] pc;
    logic [31:0] imme;
    logic [31:0] rs1;
    logic [31:0] rs2;
    logic        pred;
  } stim_t;

  typedef struct packed {
    logic        corr;
    logic        misp;
    logic [31:0] rpc;
    logic        v;
    logic [5:0]  kind;
    logic [31:0] pc;
    logic        res;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        PL_stall, PL_stall_inner, B_type_ex;
  logic        beq_ex, bne_ex, blt_ex, bge_ex, bltu_ex, bgeu_ex;
  logic [31:0] pc_ex, imme_ex, rs1_data, rs2_data;
  logic        prediction_ex;
  logic        corrected_result, mispredict;
  logic [31:0] redirect_pc;
  logic        B_type_branch_failed;
  logic        beq_branch_failed, bne_branch_failed, blt_branch_failed;
  logic        bge_branch_failed, bltu_branch_failed, bgeu_branch_failed;
  logic [31:0] pc_branch_filled;
  logic        B_type_result_branch_failed;
`ifdef BRANCH_PERF_CNT_EN
  logic [31:0] perf_branch_cnt, perf_mispredict_cnt;
`endif

  branch_resolve_unit #(
    .XLEN          (32),
    .SHADOW_CYCLES (SC)
  ) dut (
    .clk                         (clk),
    .rst_n                       (rst_n),
    .PL_stall                    (PL_stall),
    .PL_stall_inner              (PL_stall_inner),
    .B_type_ex                   (B_type_ex),
    .beq_ex                      (beq_ex),
    .bne_ex                      (bne_ex),
    .blt_ex                      (blt_ex),
    .bge_ex                      (bge_ex),
    .bltu_ex                     (bltu_ex),
    .bgeu_ex                     (bgeu_ex),
    .pc_ex                       (pc_ex),
    .imme_ex                     (imme_ex),
    .rs1_data                    (rs1_data),
    .rs2_data                    (rs2_data),
    .prediction_ex               (prediction_ex),
    .corrected_result            (corrected_result),
    .mispredict                  (mispredict),
    .redirect_pc                 (redirect_pc),
    .B_type_branch_failed        (B_type_branch_failed),
    .beq_branch_failed           (beq_branch_failed),
    .bne_branch_failed           (bne_branch_failed),
    .blt_branch_failed           (blt_branch_failed),
    .bge_branch_failed           (bge_branch_failed),
    .bltu_branch_failed          (bltu_branch_failed),
    .bgeu_branch_failed          (bgeu_branch_failed),
    .pc_branch_filled            (pc_branch_filled),
    .B_type_result_branch_failed (B_type_result_branch_failed)
`ifdef BRANCH_PERF_CNT_EN
    ,
    .perf_branch_cnt             (perf_branch_cnt),
    .perf_mispredict_cnt         (perf_mispredict_cnt)
`endif
  );

  always #5 clk = ~clk;

  int cycle = 0;
  always @(posedge clk) cycle <= cycle + 1;

  // Scoreboard and counters
  exp_t exp_q[$];
  int   n_vec    = 0;
  int   n_checks = 0;
  int   n_fail   = 0;

  // Reference model state (higher-level view: remaining wrong-path cycles)
  int          shadow_left;
  logic        m_v;
  logic [5:0]  m_kind;
  logic [31:0] m_pc;
  logic        m_res;
  longint      m_branch_cnt;
  longint      m_misp_cnt;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got 0x%08h, expected 0x%08h", name, cycle, act, exp);
    end
  endtask

  function automatic logic ref_taken(input stim_t s);
    if (!s.b || $countones(s.kind) != 1) return 1'b0;
    if (s.kind[0]) return s.rs1 == s.rs2;
    if (s.kind[1]) return s.rs1 != s.rs2;
    if (s.kind[2]) return $signed(s.rs1) <  $signed(s.rs2);
    if (s.kind[3]) return $signed(s.rs1) >= $signed(s.rs2);
    if (s.kind[4]) return s.rs1 <  s.rs2;
    return s.rs1 >= s.rs2;
  endfunction

  function automatic stim_t mk(input logic b, input logic [5:0] kind,
                               input logic [31:0] pc, input logic [31:0] imme,
                               input logic [31:0] rs1, input logic [31:0] rs2,
                               input logic pred);
    stim_t s;
    s.rst_n = 1'b1; s.ps = 1'b0; s.psi = 1'b0;
    s.b = b; s.kind = kind; s.pc = pc; s.imme = imme;
    s.rs1 = rs1; s.rs2 = rs2; s.pred = pred;
    return s;
  endfunction

  task automatic model_reset();
    shadow_left  = 0;
    m_v          = 1'b0;
    m_kind       = '0;
    m_pc         = '0;
    m_res        = 1'b0;
    m_branch_cnt = 0;
    m_misp_cnt   = 0;
  endtask

  // Drive one vector for one cycle and record what the DUT must show.
  task automatic apply(input stim_t s);
    exp_t e;
    logic taken, misp, stall, run;
    @(negedge clk);
    rst_n          = s.rst_n;
    PL_stall       = s.ps;
    PL_stall_inner = s.psi;
    B_type_ex      = s.b;
    {bgeu_ex, bltu_ex, bge_ex, blt_ex, bne_ex, beq_ex} = s.kind;
    pc_ex          = s.pc;
    imme_ex        = s.imme;
    rs1_data       = s.rs1;
    rs2_data       = s.rs2;
    prediction_ex  = s.pred;
    if (!s.rst_n) model_reset();
    taken = ref_taken(s);
    stall = s.ps || s.psi;
    run   = (shadow_left == 0);
    misp  = s.b && (taken != s.pred) && run && !stall;
    e.corr = taken;
    e.misp = misp;
    e.rpc  = taken ? s.pc + s.imme : s.pc + 32'd4;
    e.v    = m_v;
    e.kind = m_kind;
    e.pc   = m_pc;
    e.res  = m_res;
    exp_q.push_back(e);
    n_vec++;
    // Effect of the coming rising edge
    if (s.rst_n && !stall) begin
      if (s.b && run && m_branch_cnt < 64'hFFFF_FFFF) m_branch_cnt++;
      if (misp && m_misp_cnt < 64'hFFFF_FFFF) m_misp_cnt++;
      if (misp) shadow_left = SC;
      else if (shadow_left > 0) shadow_left--;
      m_v    = misp;
      m_kind = misp ? s.kind : 6'b0;
      if (misp) begin
        m_pc  = s.pc;
        m_res = taken;
      end
    end
  endtask

  // Monitor: sample well before the next rising edge and compare.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #3;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("corrected_result", 32'(corrected_result), 32'(e.corr));
        check("mispredict", 32'(mispredict), 32'(e.misp));
        check("redirect_pc", redirect_pc, e.rpc);
        check("failed_valid", 32'(B_type_branch_failed), 32'(e.v));
        check("failed_kind",
              32'({bgeu_branch_failed, bltu_branch_failed, bge_branch_failed,
                   blt_branch_failed, bne_branch_failed, beq_branch_failed}),
              32'(e.kind));
        check("pc_branch_filled", pc_branch_filled, e.pc);
        check("failed_result", 32'(B_type_result_branch_failed), 32'(e.res));
      end
    end
  end

  // Global watchdog
  initial begin
    #2000000;
    $display("FAIL watchdog at cycle %0d: simulation did not finish in time", cycle);
    $fatal(1, "watchdog expired");
  end

  initial begin
    stim_t s;
    stim_t idle;
    idle = mk(1'b0, 6'b0, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0);
    model_reset();

    // Reset
    s = idle; s.rst_n = 1'b0;
    apply(s);
    apply(s);
    apply(idle);

    // beq 5 == 5 predicted taken: correct prediction
    apply(mk(1'b1, 6'b000001, 32'h40, 32'h10, 32'd5, 32'd5, 1'b1));
    // blt -1 < 1 predicted not-taken: mispredict, redirect 0x120
    apply(mk(1'b1, 6'b000100, 32'h100, 32'h20, 32'hFFFF_FFFF, 32'd1, 1'b0));
    // Bundle visible (blt, pc 0x100, result 1)
    apply(idle);
    // bltu 0xFFFFFFFF < 1 is false, predicted taken: redirect pc+4
    apply(mk(1'b1, 6'b010000, 32'h100, 32'h20, 32'hFFFF_FFFF, 32'd1, 1'b1));
    apply(idle);
    apply(idle);

    // Back-to-back: second mispredicting branch lands in SHADOW
    apply(mk(1'b1, 6'b000001, 32'h300, 32'h8, 32'd9, 32'd9, 1'b0));
    apply(mk(1'b1, 6'b000010, 32'h304, 32'h8, 32'd1, 32'd2, 1'b0));
    apply(mk(1'b1, 6'b000010, 32'h308, 32'h8, 32'd1, 32'd2, 1'b0));
    apply(idle);

    // Mispredicting bne held by an inner stall for three cycles
    s = mk(1'b1, 6'b000010, 32'h200, 32'h40, 32'd1, 32'd2, 1'b0);
    s.psi = 1'b1;
    apply(s);
    apply(s);
    apply(s);
    s.psi = 1'b0;
    apply(s);
    apply(idle);
    apply(idle);

    // Target wrap-around
    apply(mk(1'b1, 6'b000001, 32'hFFFF_FFFC, 32'd8, 32'd7, 32'd7, 1'b1));
    apply(mk(1'b1, 6'b000001, 32'hFFFF_FFFC, 32'd8, 32'd7, 32'd7, 1'b0));
    apply(idle);

    // Randomized traffic
    for (int i = 0; i < N_RANDOM; i++) begin
      s.rst_n = ($urandom_range(0, 199) != 0);
      s.ps    = ($urandom_range(0, 9) == 0);
      s.psi   = ($urandom_range(0, 9) == 0);
      s.b     = ($urandom_range(0, 9) < 7);
      if ($urandom_range(0, 9) == 0) s.kind = 6'($urandom());
      else                           s.kind = 6'b1 << $urandom_range(0, 5);
      s.pc    = $urandom() & 32'hFFFF_FFFC;
      s.imme  = ($urandom_range(0, 1) != 0) ? 32'($signed(13'($urandom()))) : $urandom();
      s.rs1   = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 4)) : $urandom();
      case ($urandom_range(0, 3))
        0:       s.rs2 = s.rs1;
        1:       s.rs2 = 32'($urandom_range(0, 4));
        default: s.rs2 = $urandom();
      endcase
      s.pred  = $urandom_range(0, 1) != 0;
      apply(s);
    end

    apply(idle);
    @(negedge clk);
    @(negedge clk);
    check("scoreboard_drain", 32'(exp_q.size()), 32'd0);

`ifdef BRANCH_PERF_CNT_EN
    check("perf_branch_cnt", perf_branch_cnt, 32'(m_branch_cnt));
    check("perf_mispredict_cnt", perf_mispredict_cnt, 32'(m_misp_cnt));
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule

// File: doc/branch_resolve_unit.md
Name: branch_resolve_unit

Overview:
- EX-stage block directly downstream of the branch predictor.
- Evaluates each B-type branch against its operands and compares the real outcome with the prediction carried from IF/ID.
- Produces the combinational training outcome (corrected_result) and the redirect request.
- Registers the one-cycle "branch_failed" bundle that the predictor and RAS use for rollback while the pipeline flushes.

Parameters:
- XLEN, 32, operand and PC width.
- SHADOW_CYCLES, 1, cycles after a mispredict during which EX contents are treated as wrong-path and cannot raise a new mispredict (range 1..3).

Ports:
- clk  in  1  clock, all state on rising edge
- rst_n  in  1  asynchronous active-low reset
- PL_stall  in  1  global pipeline stall; holds all state
- PL_stall_inner  in  1  EX-internal stall (multicycle op); holds all state
- B_type_ex  in  1  EX instruction is a conditional branch
- beq_ex, bne_ex, blt_ex, bge_ex, bltu_ex, bgeu_ex  in  1 each  one-hot branch kind, valid only with B_type_ex
- pc_ex  in  XLEN  PC of EX instruction
- imme_ex  in  XLEN  sign-extended branch offset
- rs1_data, rs2_data  in  XLEN  forwarded operands
- prediction_ex  in  1  predicted taken, piped from IF
- corrected_result  out  1  real outcome (1 = taken), combinational
- mispredict  out  1  redirect request, combinational
- redirect_pc  out  XLEN  pc_ex+imme_ex if taken, else pc_ex+4
- B_type_branch_failed  out  1  registered failed-branch valid
- beq_branch_failed .. bgeu_branch_failed  out  1 each  registered kind of failed branch
- pc_branch_filled  out  XLEN  registered PC of failed branch
- B_type_result_branch_failed  out  1  registered real outcome of failed branch

Behaviour:
- Compare: beq eq; bne ne; blt/bge signed; bltu/bgeu unsigned.
  - corrected_result = 0 when B_type_ex = 0.
  - Illegal one-hot (zero or multiple with B_type_ex = 1) gives corrected_result = 0.
- Address arithmetic: modulo 2^XLEN, wrap-around silently.
- FSM states RUN and SHADOW; reset state is RUN.
- mispredict = B_type_ex && (corrected_result != prediction_ex) && state == RUN && !PL_stall && !PL_stall_inner.
- RUN to SHADOW on mispredict. A shadow counter loads SHADOW_CYCLES-1.
- SHADOW decrements its counter each unstalled cycle; returns to RUN when the counter is 0. Branches in EX during SHADOW never raise mispredict.
- Failed bundle, one-cycle latency: on a cycle with mispredict, the next edge captures:
  - B_type_branch_failed = 1
  - the one-hot kind
  - pc_ex
  - corrected_result
- On any other unstalled edge, valid and kind bits clear to 0. pc_branch_filled and the result bit hold their last values.
- Stall (PL_stall or PL_stall_inner): FSM, counter and bundle hold. mispredict is forced to 0 so predictor rollback is not duplicated.
- Back-to-back mispredicts are impossible by construction (SHADOW).
- Reset:
  - Registered outputs and counters are 0; FSM is RUN.
  - Combinational outputs follow inputs, with mispredict gated only by the stall and FSM terms.
  - Reset mid-SHADOW returns to RUN immediately.

Optional Feature:
- Macro BRANCH_PERF_CNT_EN.
- When defined, adds outputs perf_branch_cnt[31:0] and perf_mispredict_cnt[31:0].
  - perf_branch_cnt increments on each unstalled cycle with B_type_ex in RUN state.
  - perf_mispredict_cnt increments with mispredict.
  - Both saturate at 32'hFFFF_FFFF and reset to 0.
- When undefined, the ports and logic are absent and the interface is the one listed above.

Decomposition:
- Shared constants in define.v:
  - branch-kind index constants (BEQ..BGEU, 0..5)
  - FSM state encodings RUN = 1'b0, SHADOW = 1'b1
- One sub-module, branch_comparator: purely combinational, taking operands and one-hot kind and producing the taken bit. It is reusable by a future ID-stage early resolver.

Test Plan:
- Reset, then beq with rs1 = rs2 = 5, prediction_ex = 1 → corrected_result = 1, mispredict = 0, B_type_branch_failed stays 0.
- blt with rs1 = 32'hFFFF_FFFF, rs2 = 1, prediction_ex = 0, pc_ex = 0x100, imme = 0x20 → mispredict = 1 and redirect_pc = 0x120. Next cycle: B_type_branch_failed = 1, blt_branch_failed = 1, pc_branch_filled = 0x100, B_type_result_branch_failed = 1.
- bltu with the same operands, prediction_ex = 1 → corrected_result = 0, redirect_pc = pc_ex+4.
- Mispredict at cycle N, then a second mispredicting branch in EX at N+1 → mispredict = 0 at N+1 (SHADOW). State is RUN at N+2.
- Mispredicting bne with PL_stall_inner = 1 for 3 cycles → mispredict = 0 and bundle held during the stall. Mispredict asserts on the first unstalled cycle; bundle is valid one cycle later.
- pc_ex = 0xFFFF_FFFC, imme = 8, taken → redirect_pc = 0x0000_0004. With BRANCH_PERF_CNT_EN: 10 branches, 3 mispredicts → counters read 10 and 3.
